// File: rtl/conv_pkg.sv
// Shared constants and types for the K=3 rate-1/2 convolutional code.
// Encoder and Viterbi branch-metric logic both take their generators from here.
package conv_pkg;
  localparam int K          = 3;
  localparam int NUM_STATES = 4;

  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  typedef logic [1:0] sym_t;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } enc_state_t;
endpackage

// File: rtl/conv_branch.sv
// Combinational branch symbol for one trellis edge.
// Tap vector is {u, sr[0], sr[1]}; MSB of each generator hits u.
module conv_branch
  import conv_pkg::*;
(
  input  logic       u,
  input  logic [1:0] sr,
  output sym_t       sym
);
  logic [K-1:0] v;

  assign v   = {u, sr[0], sr[1]};
  assign sym = {^(G1 & v), ^(G0 & v)};
endmodule

// File: rtl/conv_encoder_k3.sv
// Rate-1/2 K=3 convolutional encoder with zero-tail frame termination.
// One bit in and one symbol out per handshake, single-entry output register.
module conv_encoder_k3
  import conv_pkg::*;
#(
  parameter int FRAME_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [1:0] m_sym,
  output logic       m_tail,
  output logic       m_last,
  output logic       busy
);
  localparam int CW = $clog2(FRAME_LEN + 1);

  enc_state_t    state;
  logic [1:0]    sr;
  logic [CW-1:0] data_cnt;
  logic          tail_cnt;

  logic load;
  logic accept;
  logic inject;
  logic u;
  sym_t sym_nxt;

  assign load    = !m_valid || m_ready;
  assign s_ready = (state != TAIL) && load && !rst;
  assign accept  = s_valid && s_ready;
  assign inject  = (state == TAIL) && load;
  assign u       = inject ? 1'b0 : s_data;
  assign busy    = (state != IDLE) || m_valid;

  conv_branch u_branch (
    .u   (u),
    .sr  (sr),
    .sym (sym_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= '0;
      data_cnt <= '0;
      tail_cnt <= 1'b0;
      m_valid  <= 1'b0;
      m_sym    <= '0;
      m_tail   <= 1'b0;
      m_last   <= 1'b0;
    end else begin
      if (m_valid && m_ready)
        m_valid <= 1'b0;

      if (accept || inject) begin
        m_valid <= 1'b1;
        m_sym   <= sym_nxt;
        m_tail  <= inject;
        m_last  <= inject && (tail_cnt == 1'(K - 2));
        sr      <= {sr[0], u};
      end

      unique case (state)
        IDLE: begin
          if (accept) begin
            data_cnt <= CW'(1);
            if (FRAME_LEN == 1) begin
              state    <= TAIL;
              tail_cnt <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            if (data_cnt == CW'(FRAME_LEN - 1)) begin
              state    <= TAIL;
              tail_cnt <= 1'b0;
            end else begin
              data_cnt <= data_cnt + CW'(1);
            end
          end
        end
        TAIL: begin
          if (inject) begin
            if (tail_cnt == 1'(K - 2)) begin
              // frame closed: trellis is back in state 0
              state    <= IDLE;
              sr       <= '0;
              data_cnt <= '0;
              tail_cnt <= 1'b0;
            end else begin
              tail_cnt <= tail_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/conv_encoder_k3.md
Name: conv_encoder_k3

Overview:
Rate-1/2, constraint-length-3 convolutional encoder with zero-tail frame termination. It is the transmit-side counterpart of the Viterbi decoder and produces the symbol stream that the decoder consumes. It accepts one information bit per handshake and emits one 2-bit code symbol per handshake. After every FRAME_LEN data bits it appends K-1 zero tail bits, so each frame ends in state 0.

Parameters:
K, 3, constraint length; this block supports only K=3 (4 trellis states).
G0, 3'b111, generator for symbol bit 0 (octal 7); MSB taps the current input bit.
G1, 3'b101, generator for symbol bit 1 (octal 5); MSB taps the current input bit.
FRAME_LEN, 8, data bits per frame (>=1).

Ports:
clk  in  1  single clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
s_valid  in  1  input bit valid.
s_ready  out  1  encoder accepts s_data this cycle.
s_data  in  1  information bit.
m_valid  out  1  output symbol valid.
m_ready  in  1  downstream accepts symbol.
m_sym  out  2  code symbol {c1,c0}.
m_tail  out  1  current symbol is produced by a tail bit.
m_last  out  1  current symbol is the final symbol of the frame.
busy  out  1  state is DATA or TAIL, or m_valid is high.

Behaviour:
- Reset (rst=1 at a clk edge) clears all registers: m_valid=0, m_sym=00, m_tail=0, m_last=0, busy=0, s_ready=0 during reset, state=IDLE, shift register sr=00, counters=0. Reset mid-frame discards the partial frame and emits no tail.
- Shift register sr[1:0]: sr[0] holds the previous input bit, sr[1] holds the bit before that. Tap vector v={u,sr[0],sr[1]}.
  - c0 = XOR-reduce(G0 & v); c1 = XOR-reduce(G1 & v).
  - Next sr = {sr[0],u}, i.e. sr[1]<=sr[0] and sr[0]<=u.
- Output register is single-entry. It can load when !m_valid || m_ready; call this "load".
- s_ready = (state!=TAIL) && load && !rst. Loading in the same cycle as a downstream pop is allowed, giving full throughput of 1 symbol/clk.
- Latency: the symbol appears on m_sym in the cycle after the accepting edge.
- m_valid, m_sym, m_tail and m_last are held stable while m_valid && !m_ready.
- FSM:
  - IDLE: a data accept sets data_cnt=1. Go to DATA, or to TAIL if FRAME_LEN==1.
  - DATA: each accept increments data_cnt. The accept with data_cnt==FRAME_LEN-1 goes to TAIL and sets tail_cnt=0.
  - TAIL: on each load, u=0 is internally injected, with m_tail=1. m_last=1 on the tail_cnt==K-2 symbol. That load returns to IDLE with sr=00 and counters=0.
  - s_ready=0 throughout TAIL.
- Back-to-back frames: IDLE accepts a new bit in the cycle after the last tail load, with no extra bubble.
- If s_valid and a TAIL injection are both possible, TAIL wins because s_ready=0.
- Backpressure held indefinitely causes no loss and no duplicate symbols.
- s_data is ignored when !s_valid.
- Each frame emits exactly FRAME_LEN+K-1 symbols.

Decomposition:
- Package conv_pkg holds:
  - constants K, G0, G1, and NUM_STATES=4;
  - the FSM enum enc_state_t {IDLE,DATA,TAIL};
  - the symbol type sym_t (logic [1:0]).
  - The decoder's branch-metric logic imports the same G0/G1.
- Sub-module conv_branch is pure combinational. Inputs are u and sr[1:0]; output is sym[1:0]. The decoder reuses it to compute expected branch symbols per trellis edge.
- The top level holds the FSM, counters, sr and the output register.

Test Plan:
- FRAME_LEN=4, m_ready=1, bits 1,0,1,1 on consecutive cycles -> m_sym sequence 11,01,00,10,10,11. m_tail=1 on the last two symbols, m_last=1 only on the sixth. busy drops after it.
- Same frame with m_ready toggling 1,0,0,1,... -> identical symbol sequence. No drop or duplication. m_sym stays stable while stalled. s_ready=0 whenever m_valid && !m_ready.
- Two back-to-back frames of all-ones (FRAME_LEN=4) -> each frame gives 11,10,01,01,10,11. The second frame's first bit is accepted the cycle after the first frame's m_last load. sr starts at 00 for the second frame.
- rst asserted after 2 data bits of a frame -> next cycle m_valid=0, busy=0, sr=00. No tail symbols emitted. A new frame 1,0,1,1 encodes exactly as in scenario 1.
- s_valid held high across the TAIL phase -> s_ready=0 for exactly K-1 load cycles. The held bit is accepted as the first bit of the next frame.
- FRAME_LEN=1, bit 1 -> symbols 11,01,11 with m_last on the third. FSM goes IDLE->TAIL->IDLE.
